// File: rtl/vga_frame_capture.sv
// VGA frame grabber: finds the active window from Hsync/Vsync,
// decimates it by SCALE and streams the kept pixels as word writes.
module vga_frame_capture #(
  parameter int CLKS_PER_PIXEL = 2,
  parameter int H_BP           = 48,
  parameter int H_ACTIVE       = 640,
  parameter int V_BP           = 33,
  parameter int V_ACTIVE       = 480,
  parameter int SCALE          = 4,
  parameter int ADDR_W         = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              Hsync,
  input  logic              Vsync,
  input  logic [15:0]       ColorIn,
  input  logic              Arm,
  output logic [ADDR_W-1:0] CapAddress,
  output logic [15:0]       CapData,
  output logic              CapWE,
  output logic              Busy,
  output logic              Done,
  output logic              SyncErr
);

  localparam int FRAME_WORDS = (H_ACTIVE / SCALE) * (V_ACTIVE / SCALE);
  localparam int H_END = (H_BP + H_ACTIVE) * CLKS_PER_PIXEL;
  localparam int V_END = V_BP + V_ACTIVE;
  localparam int CW = $clog2(H_END + 1) + 1;
  localparam int LW = $clog2(V_END + 1) + 1;
  localparam int PW = $clog2(CLKS_PER_PIXEL * SCALE + 1);
  localparam int VW = $clog2(SCALE + 1);

  localparam logic [CW-1:0] C_START = CW'(H_BP * CLKS_PER_PIXEL);
  localparam logic [CW-1:0] C_END   = CW'(H_END);
  localparam logic [CW-1:0] C_MAX   = '1;
  localparam logic [LW-1:0] L_START = LW'(V_BP);
  localparam logic [LW-1:0] L_END   = LW'(V_END);
  localparam logic [LW-1:0] L_MAX   = '1;
  localparam logic [PW-1:0] P_RLD   = PW'(CLKS_PER_PIXEL * SCALE - 1);
  localparam logic [VW-1:0] V_RLD   = VW'(SCALE - 1);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(FRAME_WORDS - 1);

  typedef enum logic [1:0] {IDLE, WAIT_V, FRAME, DONE} state_e;

  state_e state_q, state_d;
  logic hs_q, vs_q;
  logic [CW-1:0] cnt_q, cnt_d, c_eff;
  logic [LW-1:0] line_q, line_d;
  logic [VW-1:0] vph_q, vph_d;
  logic [PW-1:0] hph_q, hph_d, hph_eff;
  logic keep_q, keep_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic last_q, last_d;
  logic we_q, we_d;
  logic [ADDR_W-1:0] cadr_q;
  logic [15:0] cdat_q;
  logic err_q, err_d;
  logic hs_rise, vs_rise, vs_fall, lines_en;
  logic in_win, line_act, sample, fin, abort;

  assign hs_rise = Hsync & ~hs_q;
  assign vs_rise = Vsync & ~vs_q;
  assign vs_fall = ~Vsync & vs_q;
  assign lines_en = (state_q == FRAME) ||
                    (state_q == WAIT_V && vs_rise);
  assign line_act = (line_q >= L_START) && (line_q < L_END);

  // Line and pixel phases use reloading down-counters, no dividers.
  always_comb begin
    line_d  = line_q;
    vph_d   = vph_q;
    keep_d  = keep_q;
    c_eff   = cnt_q;
    hph_eff = hph_q;
    if (!lines_en) begin
      line_d = '0;
      vph_d  = '0;
      keep_d = 1'b0;
    end else if (hs_rise) begin
      c_eff   = '0;
      hph_eff = '0;
      keep_d  = line_act && (vph_q == '0);
      if (line_act)
        vph_d = (vph_q == '0) ? V_RLD : vph_q - 1'b1;
      if (line_q != L_MAX)
        line_d = line_q + 1'b1;
    end
    in_win = (c_eff >= C_START) && (c_eff < C_END);
    cnt_d  = (c_eff == C_MAX) ? c_eff : c_eff + 1'b1;
    hph_d  = hph_eff;
    if (in_win)
      hph_d = (hph_eff == '0) ? P_RLD : hph_eff - 1'b1;
  end

  always_comb begin
    sample = (state_q == FRAME) && keep_d && in_win &&
             (hph_eff == '0) && !last_q;
    fin    = sample && (addr_q == A_LAST);
    abort  = (state_q == FRAME) && vs_fall && !last_q && !fin;
    we_d   = sample && !abort;
    addr_d = addr_q;
    if (state_q != FRAME)
      addr_d = '0;
    else if (we_d && !fin)
      addr_d = addr_q + 1'b1;
    last_d = (state_q == FRAME) && (last_q || fin);
    err_d  = err_q;
    if (state_q == IDLE && Arm)
      err_d = 1'b0;
    else if (abort)
      err_d = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (Arm) state_d = WAIT_V;
      WAIT_V:  if (vs_rise) state_d = FRAME;
      FRAME:   if (last_q) state_d = DONE;
               else if (abort) state_d = IDLE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    Busy = 1'b0;
    Done = 1'b0;
    unique case (state_q)
      WAIT_V, FRAME: Busy = 1'b1;
      DONE:          Done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      cnt_q   <= '0;
      line_q  <= '0;
      vph_q   <= '0;
      hph_q   <= '0;
      keep_q  <= 1'b0;
      addr_q  <= '0;
      last_q  <= 1'b0;
      we_q    <= 1'b0;
      cadr_q  <= '0;
      cdat_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hs_q    <= Hsync;
      vs_q    <= Vsync;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      vph_q   <= vph_d;
      hph_q   <= hph_d;
      keep_q  <= keep_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
      we_q    <= we_d;
      err_q   <= err_d;
      if (we_d) begin
        cadr_q <= addr_q;
        cdat_q <= ColorIn;
      end
    end
  end

  assign CapWE      = we_q;
  assign CapAddress = cadr_q;
  assign CapData    = cdat_q;
  assign SyncErr    = err_q;

endmodule

// File: doc/vga_frame_capture.md
# vga_frame_capture

Frame-capture receiver for the VGA link: the far end of the `VGA_Controller` output. It observes `Hsync`, `Vsync` and the 16-bit colour bus on the system clock `clk`, locates the active video window, and decimates it by `SCALE` in both axes. The kept pixels are written back as a linear word stream for a frame-buffer port (`MemCont` write side). The block serves as an on-chip loopback checker for the display path and as a frame grabber for debug.

## Interface
- `CLKS_PER_PIXEL`, 2 — `clk` cycles per VGA pixel.
- `H_BP`, 48 — back-porch pixels between the `Hsync` rising edge and the first active pixel.
- `H_ACTIVE`, 640 — active pixels per line.
- `V_BP`, 33 — back-porch lines between the `Vsync` rising edge and the first active line.
- `V_ACTIVE`, 480 — active lines per frame.
- `SCALE`, 4 — keep 1 of every `SCALE` pixels and lines.
- `ADDR_W`, 15 — capture address width.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `Hsync`  in  1  horizontal sync, active low, synchronous to `clk`.
- `Vsync`  in  1  vertical sync, active low, synchronous to `clk`.
- `ColorIn`  in  16  pixel colour, synchronous to `clk`.
- `Arm`  in  1  one-cycle request to capture the next complete frame.
- `CapAddress`  out  `ADDR_W`  word address of the current write.
- `CapData`  out  16  captured pixel.
- `CapWE`  out  1  write strobe, one cycle per kept pixel.
- `Busy`  out  1  high from accepted `Arm` until `Done` or abort.
- `Done`  out  1  one-cycle pulse when the frame is complete.
- `SyncErr`  out  1  sticky error flag; cleared only by reset or by the next accepted `Arm`.

## Operation
- Definitions:
  - `FRAME_WORDS` = (H_ACTIVE/SCALE) × (V_ACTIVE/SCALE); the defaults give 160 × 120 = 19200.
  - `H_ACTIVE` and `V_ACTIVE` are multiples of `SCALE`.
- Edge detect: `Hsync` and `Vsync` are delayed one flop. A rise is current=1 with delayed=0; a fall is current=0 with delayed=1.
- FSM states: `IDLE`, `WAIT_V`, `FRAME`, `DONE`.
- `IDLE`:
  - `Arm`=1 → `WAIT_V`, `Busy`=1, `SyncErr` cleared.
  - `Arm` in any other state is ignored.
- `WAIT_V`:
  - Waits for a `Vsync` rise.
  - On the rise → `FRAME`; the line counter and address counter are cleared.
  - If `Vsync` is already low when armed, the rise at the end of the current pulse is used.
- `FRAME`:
  - Every `Hsync` rise increments the line counter (first rise → line 0) and clears the clock counter. The clock counter increments every cycle and saturates.
  - A line is kept when it is active (line ≥ `V_BP` and line < `V_BP+V_ACTIVE`) and (line−`V_BP`) mod `SCALE` = 0.
  - On a kept line, a pixel is sampled when:
    - clock count c ≥ `H_BP`·`CLKS_PER_PIXEL`,
    - c < (`H_BP`+`H_ACTIVE`)·`CLKS_PER_PIXEL`, and
    - (c − `H_BP`·`CLKS_PER_PIXEL`) mod (`CLKS_PER_PIXEL`·`SCALE`) = 0.
  - Sampling uses a down-counter reload rather than a divider.
  - Each sample issues one write: `CapData`=`ColorIn`, `CapAddress`=address counter, then the address counter increments. No multiplier is used.
  - When the write to address `FRAME_WORDS`−1 issues → `DONE`.
  - A `Vsync` fall while in `FRAME` before the last write is an abort: `SyncErr`=1, go to `IDLE`, `Busy`=0, no `Done`.
- `DONE`: `Done`=1 for one cycle, `Busy`=0, then `IDLE`.
- `CapAddress` never exceeds `FRAME_WORDS`−1. Extra active lines or pixels beyond the window produce no writes.

## Timing
- Reset values: `CapAddress`=0, `CapData`=0, `CapWE`=0, `Busy`=0, `Done`=0, `SyncErr`=0, state=`IDLE`. Reset mid-frame aborts immediately; no further `CapWE` is issued.
- Write latency: `CapWE`, `CapAddress` and `CapData` are registered and valid the cycle after the sampling cycle c. `CapData` equals `ColorIn` at cycle c.
- `Busy` rises the cycle after `Arm`.
- `Done` is asserted the cycle after the final `CapWE`.
- `Busy` falls in the same cycle `Done` is asserted, or the cycle after the abort-detect cycle.
- `SyncErr` rises the cycle after the abort-detect cycle.
- `Arm` coincident with `Done` is ignored, because the FSM is not in `IDLE`.
- A `Vsync` fall coincident with the final sample: the write completes and `Done` is asserted; no error.

## Test plan
Small configuration for all cases: `CLKS_PER_PIXEL`=1, `H_BP`=2, `H_ACTIVE`=8, `V_BP`=1, `V_ACTIVE`=4, `SCALE`=2, so `FRAME_WORDS`=8.
- Normal frame:
  - Stimulus: `Arm`, then one frame in which `ColorIn` = {line,pixel} pattern.
  - Required: exactly 8 `CapWE` at addresses 0..7, with data = pixels 0,2,4,6 of active lines 0 and 2. `Done` one cycle after address 7. `Busy` high throughout.
- No arm: run 3 frames with `Arm`=0 → no `CapWE`, `Busy`=0.
- Abort:
  - Stimulus: `Arm`, then `Vsync` drops after 5 writes.
  - Required: `SyncErr`=1, `Busy`=0, no `Done`, no further writes.
  - A subsequent `Arm` clears `SyncErr`, and the next full frame writes addresses 0..7.
- Reset mid-frame: assert `reset_n`=0 after write 3 → all outputs 0 the next cycle, no `CapWE` until re-armed.
- Re-arm: `Arm` pulsed while `Busy`=1 and again coincident with `Done` → both ignored, only one capture.
- Default parameters, 50 MHz clock with 640×480 timing → 19200 writes, last `CapAddress`=19199, `Done` once.
